// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// Stage 1 registers operands; stage 2 computes through a blocked
// carry-lookahead adder and registers result plus {C,S,V,P,Z} flags.
// Optional feature macro: ALU_CARRY_CHAIN_EN (enables ADC/SBB via carry_q).
module alu_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic [4:0]       out_flags
);

   localparam int unsigned NBLK = WIDTH / BLOCK;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_ADC = 3'b110;
   localparam logic [2:0] OP_SBB = 3'b111;

   // Reject operand widths that do not split evenly into lookahead groups
   if ((WIDTH % BLOCK) != 0 || WIDTH == 0 || BLOCK == 0) begin : g_width_check
      $error("alu_pipe: WIDTH must be a non-zero multiple of BLOCK");
   end

   logic             s1_valid;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   logic [2:0]       s1_op;
   logic             s1_move;
   logic             accept;

   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic             is_arith;
   logic [WIDTH-1:0] sum;
   logic             add_cout;
   logic             gg;
   logic             pp;
   logic             cblk;
   logic             gbit;
   logic             pbit;

   logic [WIDTH-1:0] res_z;
   logic             res_carry;
   logic             res_ovf;
   logic [4:0]       res_flags;

`ifdef ALU_CARRY_CHAIN_EN
   logic             carry_q;
`endif

   assign s1_move  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~s1_valid | s1_move;
   assign accept   = in_valid & in_ready;

   // Stage 1 operand register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_op    <= OP_ADD;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_x     <= in_x;
         s1_y     <= in_y;
         s1_op    <= in_op;
      end else if (s1_move) begin
         s1_valid <= 1'b0;
      end
   end

   // Adder operand selection: subtract as x + ~y + cin
   always_comb begin
      add_b    = s1_y;
      add_cin  = 1'b0;
      is_arith = 1'b0;
      case (s1_op)
         OP_ADD: is_arith = 1'b1;
         OP_SUB: begin
            is_arith = 1'b1;
            add_b    = ~s1_y;
            add_cin  = 1'b1;
         end
`ifdef ALU_CARRY_CHAIN_EN
         OP_ADC: begin
            is_arith = 1'b1;
            add_cin  = carry_q;
         end
         OP_SBB: begin
            is_arith = 1'b1;
            add_b    = ~s1_y;
            add_cin  = carry_q;
         end
`endif
         default: ;
      endcase
   end

   // Blocked carry-lookahead: in-group carries from group-in carry, ripple between groups
   always_comb begin
      sum  = '0;
      cblk = add_cin;
      gg   = 1'b0;
      pp   = 1'b1;
      gbit = 1'b0;
      pbit = 1'b0;
      for (int unsigned b = 0; b < NBLK; b++) begin
         gg = 1'b0;
         pp = 1'b1;
         for (int unsigned k = 0; k < BLOCK; k++) begin
            gbit = s1_x[b*BLOCK+k] & add_b[b*BLOCK+k];
            pbit = s1_x[b*BLOCK+k] ^ add_b[b*BLOCK+k];
            sum[b*BLOCK+k] = pbit ^ (gg | (pp & cblk));
            gg = gbit | (pbit & gg);
            pp = pp & pbit;
         end
         cblk = gg | (pp & cblk);
      end
      add_cout = cblk;
   end

   // Result mux and flag generation; illegal ops fall through to z=0
   always_comb begin
      res_z = '0;
      case (s1_op)
         OP_ADD, OP_SUB: res_z = sum;
         OP_AND:         res_z = s1_x & s1_y;
         OP_OR:          res_z = s1_x | s1_y;
         OP_XOR:         res_z = s1_x ^ s1_y;
         OP_NOT:         res_z = ~s1_x;
`ifdef ALU_CARRY_CHAIN_EN
         OP_ADC, OP_SBB: res_z = sum;
`endif
         default:        res_z = '0;
      endcase
      res_carry = is_arith & add_cout;
      res_ovf   = is_arith & (s1_x[WIDTH-1] == add_b[WIDTH-1])
                           & (res_z[WIDTH-1] != s1_x[WIDTH-1]);
      res_flags = {res_carry, res_z[WIDTH-1], res_ovf, ~^res_z, ~|res_z};
   end

   // Stage 2 output register; holds while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_z     <= '0;
         out_flags <= '0;
      end else if (s1_move) begin
         out_valid <= 1'b1;
         out_z     <= res_z;
         out_flags <= res_flags;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ALU_CARRY_CHAIN_EN
   // Carry chain register, updated in order by arithmetic results only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
      end else if (s1_move && is_arith) begin
         carry_q <= res_carry;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16, BLOCK=4).
// Honours ALU_CARRY_CHAIN_EN for the ADC/SBB expectations.
module tb_alu_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_z;
   logic [4:0]  out_flags;

   int n_pass;
   int n_total;

   alu_pipe #(.WIDTH(16), .BLOCK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_flags (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One op through an idle pipe with out_ready high; checks latency and result
   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] ez, input logic [4:0] ef);
      in_valid  = 1'b1;
      in_op     = op;
      in_x      = x;
      in_y      = y;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      step();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_z"}, 32'(out_z), 32'(ez));
      check({tag, "_flags"}, 32'(out_flags), 32'(ef));
   endtask

   logic [2:0]  bp_op [4];
   logic [15:0] bp_x  [4];
   logic [15:0] bp_y  [4];
   logic [15:0] bp_z  [4];

   initial begin
      int sent;
      int got;
      int cyc;
      logic in_acc;
      logic out_acc;
      logic [15:0] held_z;
      logic [4:0]  held_f;

      n_pass    = 0;
      n_total   = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_op     = 3'b000;
      out_ready = 1'b0;

      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_z", 32'(out_z), 32'd0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      step();

      // Arithmetic and logic vectors
      run_op("add_ovf",   3'b000, 16'h7FFF, 16'h0001, 16'h8000, 5'b01100);
      run_op("add_wrap",  3'b000, 16'hFFFF, 16'h0001, 16'h0000, 5'b10011);
      run_op("sub_neg",   3'b001, 16'h0003, 16'h0005, 16'hFFFE, 5'b01000);
      run_op("sub_ovf",   3'b001, 16'h8000, 16'h0001, 16'h7FFF, 5'b10100);
      run_op("sub_eq",    3'b001, 16'h1234, 16'h1234, 16'h0000, 5'b10011);
      run_op("add_plain", 3'b000, 16'h1234, 16'h4321, 16'h5555, 5'b00010);
      run_op("add_blkc",  3'b000, 16'h00FF, 16'h0001, 16'h0100, 5'b00000);
      run_op("and",       3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00010);
      run_op("or",        3'b011, 16'hF0F0, 16'h0F0F, 16'hFFFF, 5'b01010);
      run_op("xor",       3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00011);
      run_op("not",       3'b101, 16'h0000, 16'h1234, 16'hFFFF, 5'b01010);

      // Carry chain: ADD wrap then ADC issued the very next cycle
      step();
      in_valid = 1'b1; in_op = 3'b000; in_x = 16'hFFFF; in_y = 16'h0001; out_ready = 1'b1;
      step();
      in_op = 3'b110; in_x = 16'h0000; in_y = 16'h0000;
      step();
      in_valid = 1'b0;
      check("chain_add_z", 32'(out_z), 32'h0000);
      step();
      check("chain_adc_valid", 32'(out_valid), 32'd1);
`ifdef ALU_CARRY_CHAIN_EN
      check("chain_adc_z", 32'(out_z), 32'h0001);
      check("chain_adc_flags", 32'(out_flags), 32'(5'b00000));
      run_op("sbb", 3'b111, 16'h0005, 16'h0003, 16'h0001, 5'b10000);
`else
      check("chain_adc_z", 32'(out_z), 32'h0000);
      check("chain_adc_flags", 32'(out_flags), 32'(5'b00011));
      run_op("sbb_illegal", 3'b111, 16'h0005, 16'h0003, 16'h0000, 5'b00011);
`endif

      // Backpressure: four back-to-back ops with consumer stalled at first
      bp_op[0] = 3'b000; bp_x[0] = 16'h0001; bp_y[0] = 16'h0002; bp_z[0] = 16'h0003;
      bp_op[1] = 3'b001; bp_x[1] = 16'h0010; bp_y[1] = 16'h0001; bp_z[1] = 16'h000F;
      bp_op[2] = 3'b100; bp_x[2] = 16'h00FF; bp_y[2] = 16'h0F0F; bp_z[2] = 16'h0FF0;
      bp_op[3] = 3'b011; bp_x[3] = 16'h1000; bp_y[3] = 16'h0001; bp_z[3] = 16'h1001;
      step();
      step();
      sent   = 0;
      got    = 0;
      held_z = '0;
      held_f = '0;
      for (cyc = 0; cyc < 40 && got < 4; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (sent < 4);
         if (sent < 4) begin
            in_op = bp_op[sent];
            in_x  = bp_x[sent];
            in_y  = bp_y[sent];
         end
         #1;
         in_acc  = in_valid & in_ready;
         out_acc = out_valid & out_ready;
         if (cyc == 2) begin
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_sent_two", 32'(sent), 32'd2);
            held_z = out_z;
            held_f = out_flags;
         end
         if (cyc == 3 || cyc == 4) begin
            check("bp_hold_z", 32'(out_z), 32'(held_z));
            check("bp_hold_flags", 32'(out_flags), 32'(held_f));
         end
         if (out_acc) begin
            check("bp_order_z", 32'(out_z), 32'(bp_z[got]));
            got++;
         end
         if (in_acc) sent++;
         step();
      end
      in_valid = 1'b0;
      check("bp_all_emitted", 32'(got), 32'd4);
      for (int i = 0; i < 3; i++) begin
         check("bp_no_dup", 32'(out_valid), 32'd0);
         step();
      end

      // Reset while both stages hold ops
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'b000; in_x = 16'h0101; in_y = 16'h0202;
      step();
      in_x = 16'h0303;
      step();
      in_valid = 1'b0;
      check("mid_full_valid", 32'(out_valid), 32'd1);
      check("mid_full_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_z", 32'(out_z), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_no_stale", 32'(out_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
